// File: rtl/pingpong_block_ram.sv
// Double-buffered block memory: the producer fills one bank while the consumer drains the other.
// Bank ownership moves on wr_done / rd_done pulses; pointers alternate so blocks leave in order.
module pingpong_block_ram #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic                  err
);

    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q, err_d;

    // Both banks share one array; the bank bit is the address MSB.
    logic [DATA_WIDTH-1:0] mem [2*DEPTH];

    logic wr_acc, wr_commit, rd_acc, rd_release;

    always_comb begin
        wr_ready   = !full_q[wr_bank_q];
        rd_ready   = full_q[rd_bank_q];
        wr_acc     = wr_en && wr_ready;
        wr_commit  = wr_done && wr_ready;
        rd_acc     = rd_en && rd_ready;
        rd_release = rd_done && rd_ready;
    end

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        err_d      = err_q;

        // Commit and release can never target the same bank: one needs it empty, the other full.
        if (wr_commit) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (rd_acc) begin
            rd_data_d = mem[{rd_bank_q, rd_addr}];
        end
        if (((wr_en || wr_done) && !wr_ready) || ((rd_en || rd_done) && !rd_ready)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Contents are deliberately not reset so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{wr_bank_q, wr_addr}] <= wr_data;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pingpong_block_ram.sv
// Bench for pingpong_block_ram: a block-FIFO reference model feeds an expected-read queue,
// and a forked monitor checks every cycle's read output against it.
module tb_pingpong_block_ram;

    localparam int DW  = 10;
    localparam int DEP = 64;
    localparam int AW  = 6;

    typedef logic [DEP*DW-1:0] blk_t;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_done;
    logic          rd_ready;
    logic          err;

    pingpong_block_ram #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .rd_done      (rd_done),
        .rd_ready     (rd_ready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_on  = 0;

    // Model: committed blocks wait in a FIFO (at most two); cur is the block being written.
    blk_t           fifo[$];
    logic [DEP-1:0] msk_q[$];
    blk_t           cur;
    logic [DEP-1:0] cur_msk;
    bit             m_err;

    // Scoreboard of reads: expected word, cycle it must appear, and whether the word was written.
    int     exp_d[$];
    longint exp_due[$];
    bit     exp_care[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic model_clear();
        fifo.delete();
        msk_q.delete();
        cur_msk = '0;
        cur     = '0;
        m_err   = 0;
        exp_d.delete();
        exp_due.delete();
        exp_care.delete();
    endtask

    task automatic step(input bit we, input int wa, input int wd, input bit wdn,
                        input bit re, input int ra, input bit rdn);
        bit   mw;
        bit   mr;
        blk_t b;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = DW'(wd);
        wr_done = wdn;
        rd_en   = re;
        rd_addr = AW'(ra);
        rd_done = rdn;
        mw = fifo.size() < 2;
        mr = fifo.size() > 0;
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, mw});
        chk("rd_ready", {31'd0, rd_ready}, {31'd0, mr});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if ((we || wdn) && !mw) m_err = 1;
        if ((re || rdn) && !mr) m_err = 1;
        if (re && mr) begin
            b = fifo[0];
            exp_d.push_back(int'(b[ra*DW +: DW]));
            exp_care.push_back(msk_q[0][ra]);
            exp_due.push_back(cyc + 1);
        end
        if (rdn && mr) begin
            void'(fifo.pop_front());
            void'(msk_q.pop_front());
        end
        if (we && mw) begin
            cur[wa*DW +: DW] = DW'(wd);
            cur_msk[wa]      = 1'b1;
        end
        if (wdn && mw) begin
            fifo.push_back(cur);
            msk_q.push_back(cur_msk);
            cur_msk = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit hold_rd);
        rst     = 1;
        wr_en   = 0;
        wr_done = 0;
        rd_done = 0;
        rd_en   = hold_rd;
        @(posedge clk);
        #1;
        rst   = 0;
        rd_en = 0;
        model_clear();
    endtask

    task automatic write_block(input int base, input bit commit);
        for (int i = 0; i < DEP; i++) step(1, i, base + i, 0, 0, 0, 0);
        if (commit) step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic read_block(input bit release_it);
        for (int i = 0; i < DEP; i++) step(0, 0, 0, 0, 1, i, 0);
        if (release_it) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int     d;
        longint due;
        bit     care;
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
        rd_en = 0; rd_addr = '0; rd_done = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        fork
            forever begin
                @(negedge clk);
                if (mon_on) begin
                    if (exp_due.size() > 0 && exp_due[0] == cyc) begin
                        d    = exp_d.pop_front();
                        due  = exp_due.pop_front();
                        care = exp_care.pop_front();
                        chk("rd_valid", {31'd0, rd_data_valid}, 32'd1);
                        if (care) chk("rd_data", {22'd0, rd_data}, d[31:0]);
                    end else begin
                        chk("rd_idle_valid", {31'd0, rd_data_valid}, 32'd0);
                    end
                end
            end
        join_none
        mon_on = 1;

        // Reset state.
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
        chk("rst_rd_data", {22'd0, rd_data}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_data_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        idle();

        // Single block: data = addr + 100, back-to-back readout, then release.
        write_block(100, 1);
        read_block(1);
        idle();
        chk("released_rd_ready", {31'd0, rd_ready}, 32'd0);

        // Ping-pong: read A while B is written.
        write_block(0, 1);
        for (int i = 0; i < DEP; i++) step(1, i, i + 512, 0, 1, i, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        read_block(1);
        idle();

        // Both full: dropped write, err, then recovery.
        write_block(32'h155, 1);
        write_block(7, 1);
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        step(1, 5, 10'h3FF, 0, 0, 0, 0);
        chk("drop_err", {31'd0, err}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("freed_wr_ready", {31'd0, wr_ready}, 32'd1);
        read_block(1);
        idle();

        // Same-cycle commit and release.
        do_reset(0);
        write_block(200, 1);
        for (int i = 0; i < DEP - 1; i++) step(1, i, i + 300, 0, 1, i, 0);
        step(1, DEP - 1, 300 + DEP - 1, 1, 0, 0, 1);
        chk("swap_rd_ready", {31'd0, rd_ready}, 32'd1);
        chk("swap_wr_ready", {31'd0, wr_ready}, 32'd1);
        read_block(1);
        idle();

        // Reset mid-read.
        write_block(40, 1);
        step(0, 0, 0, 0, 1, 3, 0);
        do_reset(1);
        chk("midrst_rd_valid", {31'd0, rd_data_valid}, 32'd0);
        chk("midrst_rd_ready", {31'd0, rd_ready}, 32'd0);
        chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("midrst_err", {31'd0, err}, 32'd0);
        idle();

        // Randomized traffic, with a reset partway through.
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset(0);
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 1023)), $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 6, int'($urandom_range(0, 63)),
                 $urandom_range(0, 24) == 0);
        end
        repeat (3) idle();
        chk("scoreboard_drained", exp_d.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pingpong_block_ram.md
Name: pingpong_block_ram

Overview:
- Double-buffered (ping-pong) block memory between a block producer (e.g. DCT/quantiser writing an 8x8 block) and a block consumer (e.g. zigzag/entropy stage reading it).
- It is the responder end of both RAM protocols:
  - It receives the write interface: addr/en/data driven by the producer.
  - It answers the read interface: it takes addr/en and returns data.
- Two banks let the producer fill one block while the consumer drains the other.
- Bank ownership is handed over by block-done pulses.

Parameters:
- DATA_WIDTH, 10, width of each stored word.
- DEPTH, 64, words per bank (one 8x8 block); address width AW = $clog2(DEPTH).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe (ramWr Rx side).
- wr_addr  in  AW  write address within the current write bank.
- wr_data  in  DATA_WIDTH  write data.
- wr_done  in  1  one-cycle pulse: current write bank holds a complete block.
- wr_ready  out  1  a write bank is available; writes and wr_done are accepted only when high.
- rd_en  in  1  read strobe (ramRd Tx side).
- rd_addr  in  AW  read address within the current read bank.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_data_valid  out  1  rd_data holds the result of a read accepted on the previous cycle.
- rd_done  in  1  one-cycle pulse: consumer has finished the current read bank.
- rd_ready  out  1  a full bank is available for reading.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Storage: two banks of DEPTH x DATA_WIDTH, inferable as a single 2*DEPTH RAM with bank bit as address MSB. Memory contents are not reset.
- State: full[1:0] per-bank flags, wr_bank pointer, rd_bank pointer.
  - Bank states are EMPTY (full=0) and FULL (full=1).
  - The write bank is always wr_bank; the read bank is always rd_bank.
- Reset values: full=00, wr_bank=0, rd_bank=0, rd_data=0, rd_data_valid=0, err=0. Hence wr_ready=1, rd_ready=0.
- Ready flags (combinational from registers):
  - wr_ready = !full[wr_bank].
  - rd_ready = full[rd_bank].
- Write:
  - When wr_en && wr_ready, mem[wr_bank][wr_addr] <= wr_data at the clock edge.
  - The same address may be rewritten; the last write wins.
- Write commit: wr_done && wr_ready sets full[wr_bank] and toggles wr_bank in the same edge.
- Read:
  - When rd_en && rd_ready, rd_data <= mem[rd_bank][rd_addr] and rd_data_valid <= 1.
  - Otherwise rd_data_valid <= 0 and rd_data holds its value.
  - Latency: exactly 1 cycle.
  - Back-to-back reads sustain 1 word/cycle.
- Read release: rd_done && rd_ready clears full[rd_bank] and toggles rd_bank.
  - A read with rd_en in the same cycle as rd_done still completes from the old bank; rd_data_valid is 1 next cycle.
- Simultaneous wr_done and rd_done (different banks): both take effect in the same edge. A consumer releasing while the producer commits never loses a block.
- Both banks FULL: wr_ready=0 and the producer stalls. The first rd_done frees the read bank, which the write pointer is already waiting on, so wr_ready=1 on the next cycle.
- Both banks EMPTY: rd_ready=0.
- Ordering: blocks are read in the order committed, because the pointers alternate strictly.
- Errors (err set, stays 1 until rst). Each offending input is otherwise ignored with no state change:
  - wr_en or wr_done while wr_ready=0.
  - rd_en or rd_done while rd_ready=0.
- Reset mid-operation: all state returns to reset values on the next edge; any in-flight read result is discarded (rd_data_valid=0); banks are treated as empty.
- No combinational path from any input to wr_ready/rd_ready. rd_data is registered.

Test Plan:
- Reset then idle → wr_ready=1, rd_ready=0, rd_data=0, rd_data_valid=0, err=0.
- Write addr i ← i+100 for i=0..63, pulse wr_done; then read 0..63 back-to-back:
  - rd_ready=1 the cycle after wr_done.
  - rd_data=100..163 each 1 cycle after its rd_en, with rd_data_valid high for 64 consecutive cycles.
  - After rd_done, rd_ready=0.
- Ping-pong: commit block A (data=addr), then write block B (data=addr+512) while reading A:
  - Reads return A values unchanged.
  - After rd_done, reads return B values.
- Both full:
  - Commit A and B → wr_ready=0.
  - A write of 0x3FF to addr 5 is dropped and err=1.
  - After rd_done, wr_ready=1; bank B still reads back its original values.
- Same-cycle wr_done and rd_done with one bank full and one being written:
  - Next cycle full flags show only the new block, rd_ready=1, wr_ready=1.
  - No block is lost; data order is preserved.
- Reset asserted mid-read, one cycle after an rd_en → rd_data_valid=0 next cycle, rd_ready=0, wr_ready=1, err=0.
